// File: rtl/sdrc_bram_responder.sv
// Purpose : SDRAM-controller-facing responder that serves bursts from on-chip block RAM.
// Latency : write word k stored on edge k after the command edge; read word k on edge ReadLatency+k.
// Backpress: no stall path; strobes outside Idle/Init or while power controls are high are dropped and flagged.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   I_sdrc_cmd_en/_cmd      one-cycle command strobe and 3-bit command code
//   I_sdrc_addr/_data_len   word address and burst length minus one
//   I_sdrc_data/_dqm        write data and per-byte mask (1 = keep old byte)
//   I_sdram_power_down,
//   I_sdram_selfrefresh     while either is high, commands are refused
//   I_sdrc_precharge_ctrl   unused
//   O_sdrc_data             registered read data, holds last burst word
//   O_sdrc_init_done        high once the init count has elapsed
//   O_sdrc_cmd_ack          one-cycle acknowledge of an accepted command
//   protocol_error          sticky flag set by any dropped or overwritten command
module sdrc_bram_responder #(
    parameter int AddressBitWidth     = 10,
    parameter int InitCycles          = 16,
    parameter int ReadLatency         = 3,
    parameter int WriteRecoveryCycles = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        protocol_error
);
    localparam int AW    = AddressBitWidth;
    localparam int DEPTH = 1 << AW;
    localparam int ICW   = (InitCycles > 1) ? $clog2(InitCycles) : 1;
    localparam int RLW   = (ReadLatency > 2) ? $clog2(ReadLatency - 1) : 1;
    localparam int WRW   = (WriteRecoveryCycles > 1) ? $clog2(WriteRecoveryCycles) : 1;

    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_READ  = 3'b101;

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_WR_BURST, ST_WR_RECOVER, ST_RD_WAIT, ST_RD_BURST
    } state_t;

    state_t          state_q;
    logic [ICW-1:0]  init_cnt_q;
    logic            init_done_q;
    logic            ack_q;
    logic            perr_q;
    logic [31:0]     rdata_q;
    logic            pend_vld_q;
    logic [2:0]      pend_cmd_q;
    logic [AW-1:0]   pend_addr_q;
    logic [7:0]      pend_len_q;
    logic [AW-1:0]   addr_q;      // next burst address (read or write)
    logic [8:0]      left_q;      // words still to transfer
    logic [RLW-1:0]  wait_q;
    logic [WRW-1:0]  rec_q;

    logic [31:0] mem_q [DEPTH];

    logic            blocked_d;
    logic            go_d;
    logic [2:0]      cmd_d;
    logic [AW-1:0]   caddr_d;
    logic [7:0]      clen_d;
    logic            we_d;
    logic [AW-1:0]   waddr_d;
    logic            unused_d;

    assign unused_d = ^{I_sdrc_precharge_ctrl, I_sdrc_addr[20:AW]};

    // A command latched during Init takes priority in Idle. A pending write
    // takes its first data word from the bus on the edge it is processed.
    assign blocked_d = I_sdram_power_down | I_sdram_selfrefresh;
    assign go_d      = (state_q == ST_IDLE) && !blocked_d && (pend_vld_q || I_sdrc_cmd_en);
    assign cmd_d     = pend_vld_q ? pend_cmd_q  : I_sdrc_cmd;
    assign caddr_d   = pend_vld_q ? pend_addr_q : I_sdrc_addr[AW-1:0];
    assign clen_d    = pend_vld_q ? pend_len_q  : I_sdrc_data_len;

    always_comb begin
        we_d    = 1'b0;
        waddr_d = addr_q;
        if (go_d && cmd_d == CMD_WRITE) begin
            we_d    = 1'b1;
            waddr_d = caddr_d;
        end else if (state_q == ST_WR_BURST) begin
            we_d = 1'b1;
        end
    end

    // Storage is never reset; reset forces state to Init, which stops writes.
    always_ff @(posedge clk) begin
        if (we_d) begin
            for (int b = 0; b < 4; b++) begin
                if (!I_sdrc_dqm[b]) begin
                    mem_q[waddr_d][8*b +: 8] <= I_sdrc_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            ack_q       <= 1'b0;
            perr_q      <= 1'b0;
            rdata_q     <= '0;
            pend_vld_q  <= 1'b0;
            pend_cmd_q  <= '0;
            pend_addr_q <= '0;
            pend_len_q  <= '0;
            addr_q      <= '0;
            left_q      <= '0;
            wait_q      <= '0;
            rec_q       <= '0;
        end else begin
            ack_q <= 1'b0;
            if (I_sdrc_cmd_en && state_q != ST_INIT && state_q != ST_IDLE) begin
                perr_q <= 1'b1;
            end
            case (state_q)
                ST_INIT: begin
                    if (I_sdrc_cmd_en) begin
                        if (blocked_d || pend_vld_q) begin
                            perr_q <= 1'b1;
                        end
                        if (!blocked_d) begin
                            pend_vld_q  <= 1'b1;
                            pend_cmd_q  <= I_sdrc_cmd;
                            pend_addr_q <= I_sdrc_addr[AW-1:0];
                            pend_len_q  <= I_sdrc_data_len;
                        end
                    end
                    if (init_cnt_q == ICW'(InitCycles - 1)) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        init_cnt_q <= init_cnt_q + ICW'(1);
                    end
                end
                ST_IDLE: begin
                    // A live strobe colliding with a pending command is lost.
                    if (I_sdrc_cmd_en && (blocked_d || pend_vld_q)) begin
                        perr_q <= 1'b1;
                    end
                    if (go_d) begin
                        ack_q      <= 1'b1;
                        pend_vld_q <= 1'b0;
                        if (cmd_d == CMD_WRITE) begin
                            addr_q <= caddr_d + AW'(1);
                            left_q <= {1'b0, clen_d};
                            if (clen_d == 8'd0) begin
                                if (WriteRecoveryCycles == 0) begin
                                    state_q <= ST_IDLE;
                                end else begin
                                    state_q <= ST_WR_RECOVER;
                                    rec_q   <= WRW'(WriteRecoveryCycles - 1);
                                end
                            end else begin
                                state_q <= ST_WR_BURST;
                            end
                        end else if (cmd_d == CMD_READ) begin
                            addr_q <= caddr_d;
                            left_q <= {1'b0, clen_d} + 9'd1;
                            if (ReadLatency <= 1) begin
                                state_q <= ST_RD_BURST;
                            end else begin
                                state_q <= ST_RD_WAIT;
                                wait_q  <= RLW'(ReadLatency - 2);
                            end
                        end
                    end
                end
                ST_WR_BURST: begin
                    addr_q <= addr_q + AW'(1);
                    left_q <= left_q - 9'd1;
                    if (left_q == 9'd1) begin
                        if (WriteRecoveryCycles == 0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WR_RECOVER;
                            rec_q   <= WRW'(WriteRecoveryCycles - 1);
                        end
                    end
                end
                ST_WR_RECOVER: begin
                    if (rec_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rec_q <= rec_q - WRW'(1);
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= ST_RD_BURST;
                    end else begin
                        wait_q <= wait_q - RLW'(1);
                    end
                end
                ST_RD_BURST: begin
                    // One edge after the last word is presented, return to Idle.
                    if (left_q == 9'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rdata_q <= mem_q[addr_q];
                        addr_q  <= addr_q + AW'(1);
                        left_q  <= left_q - 9'd1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign O_sdrc_data      = rdata_q;
    assign O_sdrc_init_done = init_done_q;
    assign O_sdrc_cmd_ack   = ack_q;
    assign protocol_error   = perr_q;

endmodule

// File: tb/tb_sdrc_bram_responder.sv
// Purpose : self-checking bench for sdrc_bram_responder with a queue scoreboard.
// Latency : expectations are keyed by absolute clock-edge number.
// Backpress: stimulus only issues commands once the reference timing says the device is Idle.
module tb_sdrc_bram_responder;
    localparam int AW    = 10;
    localparam int IC    = 16;
    localparam int RL    = 3;
    localparam int WRC   = 1;
    localparam int MASK  = (1 << AW) - 1;

    logic        clk;
    logic        rst_n;
    logic        I_sdrc_cmd_en;
    logic [2:0]  I_sdrc_cmd;
    logic        I_sdrc_precharge_ctrl;
    logic        I_sdram_power_down;
    logic        I_sdram_selfrefresh;
    logic [20:0] I_sdrc_addr;
    logic [3:0]  I_sdrc_dqm;
    logic [31:0] I_sdrc_data;
    logic [7:0]  I_sdrc_data_len;
    logic [31:0] O_sdrc_data;
    logic        O_sdrc_init_done;
    logic        O_sdrc_cmd_ack;
    logic        protocol_error;

    sdrc_bram_responder #(
        .AddressBitWidth    (AW),
        .InitCycles         (IC),
        .ReadLatency        (RL),
        .WriteRecoveryCycles(WRC)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .I_sdrc_cmd_en        (I_sdrc_cmd_en),
        .I_sdrc_cmd           (I_sdrc_cmd),
        .I_sdrc_precharge_ctrl(I_sdrc_precharge_ctrl),
        .I_sdram_power_down   (I_sdram_power_down),
        .I_sdram_selfrefresh  (I_sdram_selfrefresh),
        .I_sdrc_addr          (I_sdrc_addr),
        .I_sdrc_dqm           (I_sdrc_dqm),
        .I_sdrc_data          (I_sdrc_data),
        .I_sdrc_data_len      (I_sdrc_data_len),
        .O_sdrc_data          (O_sdrc_data),
        .O_sdrc_init_done     (O_sdrc_init_done),
        .O_sdrc_cmd_ack       (O_sdrc_cmd_ack),
        .protocol_error       (protocol_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] e;
        logic [31:0] d;
    } exp_t;

    int          checks;
    int          errors;
    int unsigned edge_n;
    int unsigned next_free;
    exp_t        rd_q[$];
    int unsigned ack_q[$];
    exp_t        mon_x;
    logic [31:0] ref_mem [1 << AW];
    logic [31:0] wdat [256];
    logic [3:0]  wdqm [256];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: counts edges and checks every output event against the queues.
    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (rd_q.size() > 0 && rd_q[0].e == edge_n) begin
                mon_x = rd_q.pop_front();
                checks++;
                if (O_sdrc_data !== mon_x.d) begin
                    errors++;
                    $display("FAIL rdata edge %0d got %h expected %h", edge_n, O_sdrc_data, mon_x.d);
                end
            end
            if (O_sdrc_cmd_ack === 1'b1) begin
                checks++;
                if (ack_q.size() > 0 && ack_q[0] == edge_n) begin
                    void'(ack_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL unexpected_ack edge %0d got 1 expected 0", edge_n);
                end
            end
            if (ack_q.size() > 0 && ack_q[0] < edge_n) begin
                checks++;
                errors++;
                $display("FAIL missing_ack edge %0d got 0 expected 1", ack_q[0]);
                void'(ack_q.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_write(input int unsigned a, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++) begin
            if (!m[b]) ref_mem[a & MASK][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic logic [2:0] other_code(input int unsigned i);
        case (i % 6)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b011;
            4: return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    task automatic idle_inputs();
        I_sdrc_cmd_en   = 1'b0;
        I_sdrc_cmd      = 3'b000;
        I_sdrc_addr     = '0;
        I_sdrc_dqm      = 4'h0;
        I_sdrc_data     = '0;
        I_sdrc_data_len = '0;
    endtask

    // Called at a negedge; returns at the negedge just before edge tgt.
    task automatic wait_until(input int unsigned tgt);
        while (edge_n + 1 < tgt) @(negedge clk);
    endtask

    task automatic start_cmd(input logic [2:0] cmd, input int unsigned addr, input int unsigned len,
                             input logic [31:0] d, input logic [3:0] m, output int unsigned c);
        wait_until(next_free);
        c = edge_n + 1;
        I_sdrc_cmd_en   = 1'b1;
        I_sdrc_cmd      = cmd;
        I_sdrc_addr     = 21'(addr);
        I_sdrc_data_len = 8'(len);
        I_sdrc_data     = d;
        I_sdrc_dqm      = m;
    endtask

    task automatic do_write(input int unsigned addr, input int unsigned len);
        int unsigned c;
        start_cmd(3'b100, addr, len, wdat[0], wdqm[0], c);
        ack_q.push_back(c);
        for (int k = 0; k <= int'(len); k++) begin
            if (k > 0) begin
                I_sdrc_data = wdat[k];
                I_sdrc_dqm  = wdqm[k];
            end
            model_write(addr + k, wdat[k], wdqm[k]);
            @(negedge clk);
            I_sdrc_cmd_en = 1'b0;
        end
        idle_inputs();
        next_free = c + len + WRC + 1;
    endtask

    task automatic do_read(input int unsigned addr, input int unsigned len, output int unsigned c);
        exp_t x;
        start_cmd(3'b101, addr, len, $urandom, 4'h0, c);
        ack_q.push_back(c);
        for (int unsigned k = 0; k <= len; k++) begin
            x.e = c + RL + k;
            x.d = ref_mem[(addr + k) & MASK];
            rd_q.push_back(x);
        end
        // Output must still hold the last word once the device is Idle again.
        x.e = c + RL + len + 2;
        x.d = ref_mem[(addr + len) & MASK];
        rd_q.push_back(x);
        @(negedge clk);
        idle_inputs();
        next_free = c + RL + len + 2;
    endtask

    task automatic do_other(input logic [2:0] cmd, input int unsigned addr);
        int unsigned c;
        start_cmd(cmd, addr, 0, $urandom, 4'h0, c);
        ack_q.push_back(c);
        @(negedge clk);
        idle_inputs();
        next_free = c + 1;
    endtask

    task automatic release_reset(input bit with_refresh);
        int unsigned r;
        rst_n = 1'b1;
        if (with_refresh) begin
            I_sdrc_cmd_en = 1'b1;
            I_sdrc_cmd    = 3'b001;
        end
        r = edge_n + 1;
        if (with_refresh) ack_q.push_back(r + IC);
        @(negedge clk);
        idle_inputs();
        while (edge_n < r + IC - 2) @(negedge clk);
        chk("init_done_before", 32'(O_sdrc_init_done), 32'h0);
        @(negedge clk);
        chk("init_done_rise", 32'(O_sdrc_init_done), 32'h1);
        next_free = with_refresh ? r + IC + 1 : r + IC;
    endtask

    initial begin : main
        int unsigned c;
        int unsigned op;
        int unsigned off;
        int unsigned len;
        rst_n                 = 1'b0;
        I_sdrc_precharge_ctrl = 1'b0;
        I_sdram_power_down    = 1'b0;
        I_sdram_selfrefresh   = 1'b0;
        idle_inputs();
        next_free = 0;
        repeat (3) @(negedge clk);
        chk("rst_data", O_sdrc_data, 32'h0);
        chk("rst_init_done", 32'(O_sdrc_init_done), 32'h0);
        chk("rst_ack", 32'(O_sdrc_cmd_ack), 32'h0);
        chk("rst_perr", 32'(protocol_error), 32'h0);

        // Refresh strobed on the first edge after release is held until Idle.
        release_reset(1'b1);

        // Activate, then 8-word burst at 0x010 and read back.
        do_other(3'b011, 32'h010);
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 32'h11111111 * 32'(k + 1);
            wdqm[k] = 4'h0;
        end
        do_write(32'h010, 7);
        do_read(32'h010, 7, c);

        // Byte-mask merge.
        wdat[0] = 32'hAABBCCDD; wdqm[0] = 4'b0000;
        do_write(32'h020, 0);
        wdat[0] = 32'h11223344; wdqm[0] = 4'b0101;
        do_write(32'h020, 0);
        do_read(32'h020, 0, c);

        // Address wrap at the top of storage.
        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'hC0DE0000 + 32'(k);
            wdqm[k] = 4'h0;
        end
        do_write(32'h3FE, 3);
        do_read(32'h3FE, 3, c);
        do_read(32'h000, 1, c);

        chk("perr_clean", 32'(protocol_error), 32'h0);

        // Strobe during a read burst, then strobe under power-down: both dropped.
        do_read(32'h010, 7, c);
        wait_until(c + RL + 1);
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd    = 3'b100;
        I_sdrc_addr   = 21'h010;
        I_sdrc_data   = 32'hDEADBEEF;
        I_sdrc_dqm    = 4'h0;
        @(negedge clk);
        idle_inputs();
        chk("perr_burst_strobe", 32'(protocol_error), 32'h1);
        wait_until(next_free);
        I_sdram_power_down = 1'b1;
        I_sdrc_cmd_en      = 1'b1;
        I_sdrc_cmd         = 3'b100;
        I_sdrc_addr        = 21'h011;
        I_sdrc_data        = 32'hBADC0FFE;
        @(negedge clk);
        idle_inputs();
        I_sdram_power_down = 1'b0;
        next_free = edge_n + 1;
        chk("perr_sticky", 32'(protocol_error), 32'h1);
        do_read(32'h010, 1, c);

        // Randomized traffic over a pre-filled region.
        for (int k = 0; k < 128; k++) begin
            wdat[k] = $urandom;
            wdqm[k] = 4'h0;
        end
        do_write(32'h100, 127);
        for (int i = 0; i < 30; i++) begin
            next_free = next_free + $urandom_range(0, 2);
            op  = $urandom_range(0, 3);
            off = $urandom_range(0, 112);
            len = $urandom_range(0, 15);
            if (op <= 1) begin
                for (int k = 0; k <= int'(len); k++) begin
                    wdat[k] = $urandom;
                    wdqm[k] = 4'($urandom_range(0, 15));
                end
                do_write(32'h100 + off, len);
            end else if (op == 2) begin
                do_read(32'h100 + off, len, c);
            end else begin
                do_other(other_code($urandom_range(0, 5)), 32'h100 + off);
            end
        end

        // Reset in the middle of a write burst.
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 32'h0A000001 + 32'(k << 4);
            wdqm[k] = 4'h0;
        end
        do_write(32'h200, 7);
        do_read(32'h200, 7, c);
        wait_until(next_free);
        start_cmd(3'b100, 32'h200, 7, 32'hB0000000, 4'h0, c);
        ack_q.push_back(c);
        model_write(32'h200, 32'hB0000000, 4'h0);
        @(negedge clk);
        I_sdrc_cmd_en = 1'b0;
        I_sdrc_data   = 32'hB0000001;
        model_write(32'h201, 32'hB0000001, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("midrst_data", O_sdrc_data, 32'h0);
        chk("midrst_init_done", 32'(O_sdrc_init_done), 32'h0);
        chk("midrst_ack", 32'(O_sdrc_cmd_ack), 32'h0);
        chk("midrst_perr", 32'(protocol_error), 32'h0);
        repeat (3) @(negedge clk);
        release_reset(1'b0);
        do_read(32'h200, 7, c);

        wait_until(next_free + 8);
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL rd_drain got %0d pending expected 0", rd_q.size());
        end
        checks++;
        if (ack_q.size() != 0) begin
            errors++;
            $display("FAIL ack_drain got %0d pending expected 0", ack_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
